uart_tx_periph: RTL and testbench

- Memory-mapped UART transmitter peripheral; sits directly downstream of the system bridge, alongside the two timer/counter devices.
- Uses the same word-addressed register port shape as the timers: Addr[31:2], WE, Din, Dout, IRQ.
- CPU stores bytes into a small TX FIFO. An FSM serialises them as 8N1 frames on `txd`.
- Level IRQ is raised when the transmitter drains, suitable for the CPU's `hw_int` vector.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_periph.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_periph.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter peripheral: register offsets,
// FSM state encoding and STATUS bit positions.
package uart_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_MSB = 8;

    // A programmed divisor of zero still gives one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count. A pop on a full FIFO frees the
// slot that a same-cycle push then fills.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, frame FSM with
// per-frame latched baud divisor, and a level drain interrupt.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        en_q, ie_q, ovf_q, ovf_d, irq_q, irq_d, txd_q, txd_d;
    logic [15:0] div_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d, frame_div_q, frame_div_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;

    logic [1:0]    reg_sel;
    logic          wr_ctrl, wr_div, wr_txdata, wr_status;
    logic          fifo_full, fifo_empty, launch, baud_zero;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign reg_sel   = Addr[1:0];
    assign wr_ctrl   = WE & (reg_sel == REG_CTRL);
    assign wr_div    = WE & (reg_sel == REG_DIV);
    assign wr_txdata = WE & (reg_sel == REG_TXDATA);
    assign wr_status = WE & (reg_sel == REG_STATUS);
    assign unused_bits = ^{Addr[29:2], Din[31:16]};

    assign baud_zero = (baud_q == 16'd0);
    // A new frame starts from IDLE, or straight out of the last STOP cycle.
    assign launch = en_q & ~fifo_empty &
                    ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_zero));

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (wr_txdata),
        .pop_i   (launch),
        .wdata_i (Din[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        txd_d       = txd_q;
        frame_div_d = frame_div_q;
        if (launch) begin
            state_d     = ST_START;
            shift_d     = fifo_rdata;
            frame_div_d = eff_div(div_q);
            baud_d      = eff_div(div_q) - 16'd1;
            bit_cnt_d   = 3'd0;
            txd_d       = 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    if (baud_zero) begin
                        state_d   = ST_DATA;
                        baud_d    = frame_div_q - 16'd1;
                        bit_cnt_d = 3'd0;
                        txd_d     = shift_q[0];
                    end else begin
                        baud_d = baud_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_zero) begin
                        baud_d = frame_div_q - 16'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end else begin
                            shift_d   = {1'b0, shift_q[7:1]};
                            txd_d     = shift_q[1];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_d = baud_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_zero) state_d = ST_IDLE;
                    else           baud_d  = baud_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        irq_d = ie_q & en_q & fifo_empty & (state_q == ST_IDLE);
        ovf_d = ovf_q;
        if (wr_status)
            ovf_d = 1'b0;
        else if (wr_txdata & fifo_full & ~launch)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q        <= 1'b0;
            ie_q        <= 1'b0;
            div_q       <= DIV_RESET;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            txd_q       <= 1'b1;
            state_q     <= ST_IDLE;
            baud_q      <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            frame_div_q <= 16'd1;
        end else begin
            if (wr_ctrl) begin
                en_q <= Din[0];
                ie_q <= Din[1];
            end
            if (wr_div) div_q <= Din[15:0];
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
            txd_q       <= txd_d;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_div_q <= frame_div_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (reg_sel)
            REG_CTRL: Dout[1:0]  = {ie_q, en_q};
            REG_DIV:  Dout[15:0] = div_q;
            REG_STATUS: begin
                Dout[STAT_BUSY]                  = (state_q != ST_IDLE);
                Dout[STAT_FULL]                  = fifo_full;
                Dout[STAT_EMPTY]                 = fifo_empty;
                Dout[STAT_OVF]                   = ovf_q;
                Dout[STAT_CNT_MSB:STAT_CNT_LSB]  = 5'(fifo_count);
            end
            default: ;
        endcase
    end

    assign IRQ = irq_q;
    assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register reset values, 8N1 framing at
// several divisors, FIFO overflow, drain interrupt and mid-frame reset.
module tb_uart_tx_periph;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int n_vec = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    uart_tx_periph #(.FIFO_DEPTH(4), .DIV_RESET(16'd16)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = {28'd0, a};
        #1;
        check_val(tag, Dout, exp);
    endtask

    task automatic queue_frame(input logic [7:0] b, input int d);
        for (int k = 0; k < d; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < d; k++) exp_q.push_back(b[i]);
        for (int k = 0; k < d; k++) exp_q.push_back(1'b1);
    endtask

    task automatic drain_frames(input string tag);
        logic [0:0] e;
        Addr = {28'd0, REG_STATUS};
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check_val({tag, "_txd"}, {31'd0, txd}, {31'd0, e});
            check_val({tag, "_busy"}, {31'd0, Dout[STAT_BUSY]}, 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        check_reg("rst_ctrl", REG_CTRL, 32'h0);
        check_reg("rst_div", REG_DIV, 32'h10);
        check_reg("rst_txdata", REG_TXDATA, 32'h0);
        check_reg("rst_status", REG_STATUS, 32'h4);
        check_val("rst_txd", {31'd0, txd}, 32'd1);
        check_val("rst_irq", {31'd0, IRQ}, 32'd0);

        // Single 0xA5 frame at 4 clocks per bit.
        reg_write(REG_DIV, 32'd4);
        check_reg("div4", REG_DIV, 32'd4);
        reg_write(REG_CTRL, 32'd1);
        check_reg("ctrl_en", REG_CTRL, 32'd1);
        reg_write(REG_TXDATA, 32'hA5);
        queue_frame(8'hA5, 4);
        drain_frames("a5");
        step();
        check_reg("a5_idle_status", REG_STATUS, 32'h4);
        check_val("a5_idle_txd", {31'd0, txd}, 32'd1);

        // Overflow with the transmitter disabled, then back-to-back frames.
        reg_write(REG_CTRL, 32'd0);
        reg_write(REG_TXDATA, 32'h11);
        reg_write(REG_TXDATA, 32'h22);
        reg_write(REG_TXDATA, 32'h33);
        reg_write(REG_TXDATA, 32'h44);
        check_reg("full_no_ovf", REG_STATUS, 32'h42);
        reg_write(REG_TXDATA, 32'h55);
        check_reg("ovf_status", REG_STATUS, 32'h4A);
        check_val("ovf_txd", {31'd0, txd}, 32'd1);
        reg_write(REG_STATUS, 32'd0);
        check_reg("ovf_clear", REG_STATUS, 32'h42);
        reg_write(REG_CTRL, 32'd1);
        queue_frame(8'h11, 4);
        queue_frame(8'h22, 4);
        queue_frame(8'h33, 4);
        queue_frame(8'h44, 4);
        drain_frames("b2b");
        step();
        check_reg("b2b_idle_status", REG_STATUS, 32'h4);
        check_val("b2b_idle_txd", {31'd0, txd}, 32'd1);

        // Divisor zero behaves as one clock per bit.
        reg_write(REG_DIV, 32'd0);
        check_reg("div0", REG_DIV, 32'd0);
        reg_write(REG_TXDATA, 32'h00);
        queue_frame(8'h00, 1);
        drain_frames("d0");
        step();
        check_reg("d0_idle_status", REG_STATUS, 32'h4);

        // Drain interrupt: frame of 20 cycles, IRQ one cycle after IDLE.
        reg_write(REG_DIV, 32'd2);
        reg_write(REG_TXDATA, 32'h5A);
        reg_write(REG_CTRL, 32'd3);
        check_val("irq_start_txd", {31'd0, txd}, 32'd0);
        check_val("irq_in_frame", {31'd0, IRQ}, 32'd0);
        for (int i = 0; i < 19; i++) begin
            step();
            check_val("irq_in_frame", {31'd0, IRQ}, 32'd0);
        end
        step();
        check_reg("irq_idle_status", REG_STATUS, 32'h4);
        check_val("irq_idle_edge", {31'd0, IRQ}, 32'd0);
        step();
        check_val("irq_set", {31'd0, IRQ}, 32'd1);
        reg_write(REG_CTRL, 32'd1);
        step();
        check_val("irq_cleared", {31'd0, IRQ}, 32'd0);

        // Reset in the middle of DATA with two bytes still queued.
        reg_write(REG_DIV, 32'd4);
        reg_write(REG_TXDATA, 32'hF0);
        reg_write(REG_TXDATA, 32'h21);
        reg_write(REG_TXDATA, 32'h42);
        repeat (10) step();
        check_reg("pre_rst_status", REG_STATUS, 32'h21);
        check_val("pre_rst_txd", {31'd0, txd}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_val("rst_mid_txd", {31'd0, txd}, 32'd1);
        check_reg("rst_mid_status", REG_STATUS, 32'h4);
        step();
        step();
        reset = 1'b1;
        step();
        check_reg("post_rst_status", REG_STATUS, 32'h4);
        check_reg("post_rst_ctrl", REG_CTRL, 32'h0);
        check_reg("post_rst_div", REG_DIV, 32'h10);
        for (int i = 0; i < 50; i++) begin
            step();
            check_val("post_rst_idle_txd", {31'd0, txd}, 32'd1);
        end
        check_reg("post_rst_final_status", REG_STATUS, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
